// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the direct-mapped data cache.
//   state_e  - controller FSM states
//   WORD_W   - data / address word width
//   CNT_W    - width of the hit / miss statistics counters
//   sat_inc  - increment that holds at all-ones
package dcache_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for a direct-mapped cache of
// one-word lines.
//   clk_i, rst_i  - clock; asynchronous active-high reset (clears valid only)
//   idx_i, tag_i  - line index and tag of the current CPU address
//   hit_o         - line valid and tag matches (combinational)
//   rdata_o       - data word of the indexed line (combinational)
//   we_i, wdata_i - on a clock edge with we_i high, the indexed line becomes
//                   valid with tag_i and wdata_i
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int LINES = 16,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = WORD_W - IDX_W - 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              hit_o,
  output logic [WORD_W-1:0] rdata_o,
  input  logic              we_i,
  input  logic [WORD_W-1:0] wdata_i
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [WORD_W-1:0] data_mem [LINES];

  assign hit_o   = valid_q[idx_i] && (tag_mem[idx_i] == tag_i);
  assign rdata_o = data_mem[idx_i];

  always_comb begin
    valid_d = valid_q;
    if (we_i) valid_d[idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data carry no reset; a line is meaningless until its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_mem[idx_i]  <= tag_i;
      data_mem[idx_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// between the CPU MEM stage and a variable-latency backing memory.
//   clk_i, rst_i        - clock; asynchronous active-high reset
//   cpu_addr_i          - byte address (bits [1:0] ignored)
//   cpu_wdata_i         - store data
//   cpu_rd_i, cpu_wr_i  - load / store request (both high = store)
//   cpu_rdata_o         - load data (hit data, or memory data in the ack cycle)
//   cpu_stall_o         - pipeline freeze
//   mem_req_o, mem_we_o - backing-memory request and direction
//   mem_addr_o          - word-aligned address
//   mem_wdata_o         - write data
//   mem_rdata_i         - read data, valid with mem_ack_i
//   mem_ack_i           - one-cycle completion pulse
//   hit_cnt_o           - saturating load-hit count
//   miss_cnt_o          - saturating load-miss count
//
// state   | meaning
// IDLE    | accept a request; loads that hit complete here
// RD_MISS | read line from memory, fill at the ack edge
// WR_THRU | write word to memory, update line at the ack edge if it hits
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter  int LINES = 16,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_wdata_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  output logic [WORD_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int TAG_W = WORD_W - IDX_W - 2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              arr_hit;
  logic [WORD_W-1:0] arr_rdata;
  logic              arr_we;
  logic [WORD_W-1:0] arr_wdata;
  logic              addr_lsb_unused;

  assign idx = cpu_addr_i[IDX_W+1:2];
  assign tag = cpu_addr_i[WORD_W-1:IDX_W+2];

  // The byte offset inside the word has no effect on the cache or the memory.
  assign addr_lsb_unused = |cpu_addr_i[1:0];

  // The CPU holds its inputs while stalled, so address and data can be
  // forwarded directly and stay constant for the whole request.
  assign mem_addr_o  = {cpu_addr_i[WORD_W-1:2], 2'b00};
  assign mem_wdata_o = cpu_wdata_i;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

  dcache_array #(
    .LINES(LINES)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .idx_i  (idx),
    .tag_i  (tag),
    .hit_o  (arr_hit),
    .rdata_o(arr_rdata),
    .we_i   (arr_we),
    .wdata_i(arr_wdata)
  );

  always_comb begin
    state_d     = state_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    cpu_rdata_o = '0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    arr_we      = 1'b0;
    arr_wdata   = cpu_wdata_i;

    case (state_q)
      IDLE: begin
        // A store takes priority when both requests are raised.
        if (cpu_wr_i) begin
          cpu_stall_o = 1'b1;
          state_d     = WR_THRU;
        end else if (cpu_rd_i) begin
          if (arr_hit) begin
            cpu_rdata_o = arr_rdata;
            hit_cnt_d   = sat_inc(hit_cnt_q);
          end else begin
            cpu_stall_o = 1'b1;
            miss_cnt_d  = sat_inc(miss_cnt_q);
            state_d     = RD_MISS;
          end
        end
      end

      RD_MISS: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          cpu_rdata_o = mem_rdata_i;
          arr_we      = 1'b1;
          arr_wdata   = mem_rdata_i;
          state_d     = IDLE;
        end else begin
          cpu_stall_o = 1'b1;
        end
      end

      WR_THRU: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_ack_i) begin
          // No write allocate: only a line already holding this address is updated.
          arr_we  = arr_hit;
          state_d = IDLE;
        end else begin
          cpu_stall_o = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic        cpu_rd_i;
  logic        cpu_wr_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [15:0] hit_cnt_o;
  logic [15:0] miss_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_ctrl #(.LINES(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_rd_i   (cpu_rd_i),
    .cpu_wr_i   (cpu_wr_i),
    .cpu_rdata_o(cpu_rdata_o),
    .cpu_stall_o(cpu_stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i  (mem_ack_i),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mrdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic        exp_req;
    logic        exp_we;
    logic [15:0] exp_hit;
    logic [15:0] exp_miss;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  // One CPU access with the bench acting as backing memory: the ack arrives
  // when mem_req_o has already been high for lat cycles.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat, input logic [31:0] mrdata,
                        output int stall_cycles, output logic [31:0] rdata_seen,
                        output logic req_seen, output logic we_seen,
                        output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                        output logic stable, output logic done);
    int req_cyc;
    stall_cycles = 0;
    req_cyc      = 0;
    rdata_seen   = '0;
    req_seen     = 1'b0;
    we_seen      = 1'b0;
    addr_seen    = '0;
    wdata_seen   = '0;
    stable       = 1'b1;
    done         = 1'b0;
    @(negedge clk_i);
    cpu_rd_i    = rd;
    cpu_wr_i    = wr;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (mem_req_o) begin
        req_cyc++;
        if (req_cyc == 1) begin
          req_seen   = 1'b1;
          we_seen    = mem_we_o;
          addr_seen  = mem_addr_o;
          wdata_seen = mem_wdata_o;
        end else if (mem_we_o !== we_seen || mem_addr_o !== addr_seen ||
                     mem_wdata_o !== wdata_seen) begin
          stable = 1'b0;
        end
        if (req_cyc == lat + 1) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mrdata;
        end
      end
      #1;
      if (cpu_stall_o) stall_cycles++;
      else begin
        done       = 1'b1;
        rdata_seen = cpu_rdata_o;
      end
      @(posedge clk_i);
      #1;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'hFFFF_FFFF;
      if (done) begin
        cpu_rd_i = 1'b0;
        cpu_wr_i = 1'b0;
      end else begin
        @(negedge clk_i);
      end
    end
    cpu_rd_i = 1'b0;
    cpu_wr_i = 1'b0;
  endtask

  int          st;
  logic [31:0] rdv, av, wdv;
  logic        rq, wev, stb, dn;

  initial begin
    // rd, wr, addr, wdata, lat, mrdata, stall, rdata, req, we, hit, miss
    vecs[0]  = '{1'b1, 1'b0, 32'h40, 32'h0,        3, 32'hDEADBEEF, 4, 32'hDEADBEEF, 1'b1, 1'b0, 16'd0, 16'd1};
    vecs[1]  = '{1'b1, 1'b0, 32'h40, 32'h0,        1, 32'hBAD0BAD0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[2]  = '{1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2, 32'hBAD0BAD0, 3, 32'h0,        1'b1, 1'b1, 16'd1, 16'd1};
    vecs[3]  = '{1'b1, 1'b0, 32'h40, 32'h0,        1, 32'hBAD0BAD0, 0, 32'hCAFEF00D, 1'b0, 1'b0, 16'd2, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 32'h80, 32'h12345678, 1, 32'hBAD0BAD0, 2, 32'h0,        1'b1, 1'b1, 16'd2, 16'd1};
    vecs[5]  = '{1'b1, 1'b0, 32'h40, 32'h0,        1, 32'hBAD0BAD0, 0, 32'hCAFEF00D, 1'b0, 1'b0, 16'd3, 16'd1};
    vecs[6]  = '{1'b1, 1'b0, 32'h80, 32'h0,        2, 32'h12345678, 3, 32'h12345678, 1'b1, 1'b0, 16'd3, 16'd2};
    vecs[7]  = '{1'b1, 1'b0, 32'h40, 32'h0,        1, 32'hCAFEF00D, 2, 32'hCAFEF00D, 1'b1, 1'b0, 16'd3, 16'd3};
    vecs[8]  = '{1'b1, 1'b0, 32'h84, 32'h0,        5, 32'hA5A50001, 6, 32'hA5A50001, 1'b1, 1'b0, 16'd3, 16'd4};
    vecs[9]  = '{1'b1, 1'b0, 32'h84, 32'h0,        1, 32'hBAD0BAD0, 0, 32'hA5A50001, 1'b0, 1'b0, 16'd4, 16'd4};
    vecs[10] = '{1'b1, 1'b0, 32'h80, 32'h0,        1, 32'h11112222, 2, 32'h11112222, 1'b1, 1'b0, 16'd4, 16'd5};
    vecs[11] = '{1'b1, 1'b1, 32'h84, 32'h0BADCAFE, 1, 32'hBAD0BAD0, 2, 32'h0,        1'b1, 1'b1, 16'd4, 16'd5};
    vecs[12] = '{1'b1, 1'b0, 32'h84, 32'h0,        1, 32'hBAD0BAD0, 0, 32'h0BADCAFE, 1'b0, 1'b0, 16'd5, 16'd5};
    vecs[13] = '{1'b1, 1'b0, 32'h43, 32'h0,        1, 32'h55AA55AA, 2, 32'h55AA55AA, 1'b1, 1'b0, 16'd5, 16'd6};
    vecs[14] = '{1'b1, 1'b0, 32'h40, 32'h0,        1, 32'hBAD0BAD0, 0, 32'h55AA55AA, 1'b0, 1'b0, 16'd6, 16'd6};
    vecs[15] = '{1'b0, 1'b1, 32'h44, 32'h00000099, 1, 32'hBAD0BAD0, 2, 32'h0,        1'b1, 1'b1, 16'd6, 16'd6};
    vecs[16] = '{1'b1, 1'b0, 32'h84, 32'h0,        1, 32'hBAD0BAD0, 0, 32'h0BADCAFE, 1'b0, 1'b0, 16'd7, 16'd6};

    rst_i       = 1'b1;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    cpu_rd_i    = 1'b0;
    cpu_wr_i    = 1'b0;
    mem_rdata_i = 32'hFFFF_FFFF;
    mem_ack_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_stall", {31'b0, cpu_stall_o}, 32'd0);
    check("reset_req",   {31'b0, mem_req_o},   32'd0);
    check("reset_we",    {31'b0, mem_we_o},    32'd0);
    check("reset_hit",   {16'b0, hit_cnt_o},   32'd0);
    check("reset_miss",  {16'b0, miss_cnt_o},  32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("idle_rdata", cpu_rdata_o, 32'd0);

    for (int i = 0; i < NV; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].mrdata,
             st, rdv, rq, wev, av, wdv, stb, dn);
      check($sformatf("v%0d_done", i), {31'b0, dn}, 32'd1);
      check($sformatf("v%0d_stall_cycles", i), st, vecs[i].exp_stall);
      check($sformatf("v%0d_req", i), {31'b0, rq}, {31'b0, vecs[i].exp_req});
      if (vecs[i].rd && !vecs[i].wr)
        check($sformatf("v%0d_rdata", i), rdv, vecs[i].exp_rdata);
      if (vecs[i].exp_req) begin
        check($sformatf("v%0d_mem_we", i), {31'b0, wev}, {31'b0, vecs[i].exp_we});
        check($sformatf("v%0d_mem_addr", i), av, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("v%0d_mem_stable", i), {31'b0, stb}, 32'd1);
        if (vecs[i].exp_we)
          check($sformatf("v%0d_mem_wdata", i), wdv, vecs[i].wdata);
      end
      check($sformatf("v%0d_hit_cnt", i), {16'b0, hit_cnt_o}, {16'b0, vecs[i].exp_hit});
      check($sformatf("v%0d_miss_cnt", i), {16'b0, miss_cnt_o}, {16'b0, vecs[i].exp_miss});
    end

    // Reset while a read miss is outstanding: request drops without a clock edge.
    @(negedge clk_i);
    cpu_addr_i = 32'h100;
    cpu_rd_i   = 1'b1;
    @(negedge clk_i);
    #1;
    check("abort_req_before", {31'b0, mem_req_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("abort_req_async", {31'b0, mem_req_o}, 32'd0);
    cpu_rd_i = 1'b0;
    #1;
    check("abort_stall", {31'b0, cpu_stall_o}, 32'd0);
    check("abort_miss_cnt", {16'b0, miss_cnt_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // 0x84 was cached before reset; valid bits are gone so it must miss.
    access(1'b1, 1'b0, 32'h84, 32'h0, 1, 32'h00000077, st, rdv, rq, wev, av, wdv, stb, dn);
    check("post_rst_stall_cycles", st, 32'd2);
    check("post_rst_rdata", rdv, 32'h00000077);
    check("post_rst_miss_cnt", {16'b0, miss_cnt_o}, 32'd1);
    check("post_rst_hit_cnt", {16'b0, hit_cnt_o}, 32'd0);

    // Back-to-back hits every cycle drive hit_cnt up to saturation.
    @(negedge clk_i);
    cpu_addr_i = 32'h84;
    cpu_rd_i   = 1'b1;
    repeat (65534) @(posedge clk_i);
    #1;
    check("sat_hit_fffe", {16'b0, hit_cnt_o}, 32'h0000FFFE);
    repeat (3) @(posedge clk_i);
    #1;
    check("sat_hit_ffff", {16'b0, hit_cnt_o}, 32'h0000FFFF);
    check("sat_stall", {31'b0, cpu_stall_o}, 32'd0);
    cpu_rd_i = 1'b0;
    check("sat_miss_cnt", {16'b0, miss_cnt_o}, 32'd1);

    // A stray ack in IDLE must not start anything or fill the line.
    @(negedge clk_i);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0BAD_0BAD;
    #1;
    check("idle_ack_stall", {31'b0, cpu_stall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hFFFF_FFFF;
    check("idle_ack_req", {31'b0, mem_req_o}, 32'd0);
    access(1'b1, 1'b0, 32'h84, 32'h0, 1, 32'hBAD0BAD0, st, rdv, rq, wev, av, wdv, stb, dn);
    check("idle_ack_no_fill_stall", st, 32'd0);
    check("idle_ack_no_fill_rdata", rdv, 32'h00000077);
    check("idle_ack_hit_sat", {16'b0, hit_cnt_o}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
